mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM latch, resettable data memory, MEM/WB latch.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [4:0]  WriteReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic        Stall,
    input  logic        Flush,
    output logic [31:0] MEM_ALUResult,
    output logic [4:0]  MEM_WriteReg,
    output logic        MEM_RegWrite,
    output logic [31:0] WB_Result,
    output logic [4:0]  WB_WriteReg,
    output logic        WB_RegWrite,
    output logic        MisalignErr
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    // EX/MEM latch
    logic [31:0] ex_mem_alu_q;
    logic [31:0] ex_mem_wdata_q;
    logic [4:0]  ex_mem_wreg_q;
    logic        ex_mem_mem_read_q;
    logic        ex_mem_mem_write_q;
    logic        ex_mem_reg_write_q;
    logic        ex_mem_mem_to_reg_q;

    // MEM/WB latch
    logic [31:0] wb_result_q;
    logic [4:0]  wb_wreg_q;
    logic        wb_reg_write_q;

    logic [31:0] mem_q [MEM_WORDS];

    logic            advance;
    logic [IdxW-1:0] idx;
    logic [31:0]     rdata;
    logic            misalign;
    logic            do_write;

    // Flush overrides Stall, so a flushed cycle still retires the MEM instruction.
    assign advance  = ~Stall | Flush;
    assign idx      = ex_mem_alu_q[IdxW+1:2];
    assign rdata    = mem_q[idx];
    assign do_write = ex_mem_mem_write_q & advance & ~misalign;

`ifdef MEM_MISALIGN_TRAP_EN
    logic err_q;

    assign misalign = (ex_mem_mem_read_q | ex_mem_mem_write_q) & (ex_mem_alu_q[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (advance && misalign) begin
            err_q <= 1'b1;
        end
    end

    assign MisalignErr = err_q;
`else
    logic unused_mem_read;

    assign unused_mem_read = ex_mem_mem_read_q;
    assign misalign        = 1'b0;
    assign MisalignErr     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_alu_q        <= '0;
            ex_mem_wdata_q      <= '0;
            ex_mem_wreg_q       <= '0;
            ex_mem_mem_read_q   <= 1'b0;
            ex_mem_mem_write_q  <= 1'b0;
            ex_mem_reg_write_q  <= 1'b0;
            ex_mem_mem_to_reg_q <= 1'b0;
        end else if (Flush) begin
            ex_mem_alu_q        <= '0;
            ex_mem_wdata_q      <= '0;
            ex_mem_wreg_q       <= '0;
            ex_mem_mem_read_q   <= 1'b0;
            ex_mem_mem_write_q  <= 1'b0;
            ex_mem_reg_write_q  <= 1'b0;
            ex_mem_mem_to_reg_q <= 1'b0;
        end else if (!Stall) begin
            ex_mem_alu_q        <= ALUResult;
            ex_mem_wdata_q      <= WriteData;
            ex_mem_wreg_q       <= WriteReg;
            ex_mem_mem_read_q   <= MemRead;
            ex_mem_mem_write_q  <= MemWrite;
            ex_mem_reg_write_q  <= RegWrite;
            ex_mem_mem_to_reg_q <= MemToReg;
        end
    end

    // A store that also requests MemToReg still returns the address, not memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_result_q    <= '0;
            wb_wreg_q      <= '0;
            wb_reg_write_q <= 1'b0;
        end else if (advance) begin
            wb_result_q    <= (ex_mem_mem_to_reg_q && !ex_mem_mem_write_q) ? rdata : ex_mem_alu_q;
            wb_wreg_q      <= ex_mem_wreg_q;
            wb_reg_write_q <= ex_mem_reg_write_q & ~misalign;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            mem_q[idx] <= ex_mem_wdata_q;
        end
    end

    assign MEM_ALUResult = ex_mem_alu_q;
    assign MEM_WriteReg  = ex_mem_wreg_q;
    assign MEM_RegWrite  = ex_mem_reg_write_q;
    assign WB_Result     = wb_result_q;
    assign WB_WriteReg   = wb_wreg_q;
    assign WB_RegWrite   = wb_reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with scoreboard queues plus
// hand-written stall, flush, reset and misalignment sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResult, WriteData;
    logic [4:0]  WriteReg;
    logic        MemRead, MemWrite, RegWrite, MemToReg, Stall, Flush;
    logic [31:0] MEM_ALUResult, WB_Result;
    logic [4:0]  MEM_WriteReg, WB_WriteReg;
    logic        MEM_RegWrite, WB_RegWrite, MisalignErr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        mr, mw, rw, m2r;
        logic [31:0] exp_res;
        logic [4:0]  exp_reg;
        logic        exp_rw;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [4:0]  wreg;
        logic        rw;
    } exp_t;

    vec_t vecs[9];
    exp_t mem_sb[$];
    exp_t wb_sb[$];

    mem_stage #(.MEM_WORDS(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .WriteReg     (WriteReg),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .Stall        (Stall),
        .Flush        (Flush),
        .MEM_ALUResult(MEM_ALUResult),
        .MEM_WriteReg (MEM_WriteReg),
        .MEM_RegWrite (MEM_RegWrite),
        .WB_Result    (WB_Result),
        .WB_WriteReg  (WB_WriteReg),
        .WB_RegWrite  (WB_RegWrite),
        .MisalignErr  (MisalignErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                                input logic mr, input logic mw, input logic rw, input logic m2r,
                                input logic [31:0] er, input logic [4:0] eg, input logic erw);
        vec_t v;
        v.alu = alu; v.wdata = wd; v.wreg = wr;
        v.mr = mr; v.mw = mw; v.rw = rw; v.m2r = m2r;
        v.exp_res = er; v.exp_reg = eg; v.exp_rw = erw;
        return v;
    endfunction

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic st, input logic fl);
        ALUResult = alu; WriteData = wd; WriteReg = wr;
        MemRead = mr; MemWrite = mw; RegWrite = rw; MemToReg = m2r;
        Stall = st; Flush = fl;
    endtask

    task automatic bubble();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sb_check();
        exp_t e;
        while (mem_sb.size() > 0 && mem_sb[0].due == cyc) begin
            e = mem_sb.pop_front();
            chk("sb_mem_alu", MEM_ALUResult, e.res);
            chk("sb_mem_wreg", 32'(MEM_WriteReg), 32'(e.wreg));
            chk("sb_mem_rw", 32'(MEM_RegWrite), 32'(e.rw));
        end
        while (wb_sb.size() > 0 && wb_sb[0].due == cyc) begin
            e = wb_sb.pop_front();
            chk("sb_wb_result", WB_Result, e.res);
            chk("sb_wb_wreg", 32'(WB_WriteReg), 32'(e.wreg));
            chk("sb_wb_rw", 32'(WB_RegWrite), 32'(e.rw));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sb_check();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_alu"}, MEM_ALUResult, 32'h0);
        chk({tag, "_mem_wreg"}, 32'(MEM_WriteReg), 32'h0);
        chk({tag, "_mem_rw"}, 32'(MEM_RegWrite), 32'h0);
        chk({tag, "_wb_result"}, WB_Result, 32'h0);
        chk({tag, "_wb_wreg"}, 32'(WB_WriteReg), 32'h0);
        chk({tag, "_wb_rw"}, 32'(WB_RegWrite), 32'h0);
        chk({tag, "_misalign"}, 32'(MisalignErr), 32'h0);
    endtask

    task automatic load_and_check(input string name, input logic [31:0] addr, input logic [4:0] wr,
                                  input logic [31:0] exp);
        drive(addr, 32'h0, wr, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bubble();
        step();
        chk(name, WB_Result, exp);
        chk({name, "_wreg"}, 32'(WB_WriteReg), 32'(wr));
    endtask

    initial begin
        exp_t e;
        // alu, wdata, wreg, mr, mw, rw, m2r, exp_wb_result, exp_wb_reg, exp_wb_rw
        vecs[0] = mk(32'h10,  32'hDEADBEEF, 5'd0,  0, 1, 0, 0, 32'h10,       5'd0,  0);
        vecs[1] = mk(32'h10,  32'h0,        5'd8,  1, 0, 1, 1, 32'hDEADBEEF, 5'd8,  1);
        vecs[2] = mk(32'h1234, 32'h0,       5'd3,  0, 0, 1, 0, 32'h1234,     5'd3,  1);
        vecs[3] = mk(32'h44,  32'hCAFEF00D, 5'd5,  1, 1, 1, 1, 32'h44,       5'd5,  1);
        vecs[4] = mk(32'h44,  32'h0,        5'd6,  1, 0, 1, 1, 32'hCAFEF00D, 5'd6,  1);
        vecs[5] = mk(32'h110, 32'h0,        5'd7,  1, 0, 1, 1, 32'hDEADBEEF, 5'd7,  1);
        vecs[6] = mk(32'h20,  32'h0,        5'd9,  1, 0, 1, 1, 32'h0,        5'd9,  1);
        vecs[7] = mk(32'hFC,  32'h0BADF00D, 5'd0,  0, 1, 0, 0, 32'hFC,       5'd0,  0);
        vecs[8] = mk(32'h1FC, 32'h0,        5'd10, 1, 0, 1, 1, 32'h0BADF00D, 5'd10, 1);

        reset = 1'b1;
        bubble();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Table: back-to-back issue, expectations retire through the scoreboards.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].alu, vecs[i].wdata, vecs[i].wreg, vecs[i].mr, vecs[i].mw,
                  vecs[i].rw, vecs[i].m2r, 1'b0, 1'b0);
            e.due = cyc + 1; e.res = vecs[i].alu; e.wreg = vecs[i].wreg; e.rw = vecs[i].rw;
            mem_sb.push_back(e);
            e.due = cyc + 2; e.res = vecs[i].exp_res; e.wreg = vecs[i].exp_reg;
            e.rw = vecs[i].exp_rw;
            wb_sb.push_back(e);
            step();
        end
        bubble();
        step();
        step();
        chk("sb_drained", 32'(mem_sb.size() + wb_sb.size()), 32'h0);

        // Stall while a store sits in EX/MEM.
        drive(32'h777, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h20, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h20, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wb_result", WB_Result, 32'h777);
            chk("stall_wb_wreg", 32'(WB_WriteReg), 32'd11);
            chk("stall_wb_rw", 32'(WB_RegWrite), 32'h1);
            chk("stall_mem_alu", MEM_ALUResult, 32'h20);
        end
        Stall = 1'b0;
        step();
        chk("unstall_wb_result", WB_Result, 32'h20);
        chk("unstall_wb_rw", 32'(WB_RegWrite), 32'h0);
        bubble();
        step();
        chk("stall_load_data", WB_Result, 32'h55);
        chk("stall_load_wreg", 32'(WB_WriteReg), 32'd12);

        // Flush beats Stall: the store is bubbled before it reaches memory.
        drive(32'h30, 32'h99, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk("flush_mem_rw", 32'(MEM_RegWrite), 32'h0);
        bubble();
        step();
        step();
        load_and_check("flush_load", 32'h30, 5'd15, 32'h0);

        // Reset between the store's EX and MEM cycles.
        drive(32'h40, 32'h1111, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bubble();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        step();
        chk_all_zero("reset_held");
        #2;
        reset = 1'b0;
        step();
        load_and_check("reset_load_40", 32'h40, 5'd16, 32'h0);
        load_and_check("reset_load_10", 32'h10, 5'd17, 32'h0);

        // Misaligned store to 0x13, then loads of 0x10 and 0x13.
        drive(32'h13, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h10, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h13, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_load_10", WB_Result, 32'h0);
        chk("mis_err_set", 32'(MisalignErr), 32'h1);
`else
        chk("mis_load_10", WB_Result, 32'hA5A5A5A5);
        chk("mis_err_tied", 32'(MisalignErr), 32'h0);
`endif
        bubble();
        step();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_load_rw", 32'(WB_RegWrite), 32'h0);
`else
        chk("mis_load_rw", 32'(WB_RegWrite), 32'h1);
        chk("mis_load_13", WB_Result, 32'hA5A5A5A5);
`endif
        step();
        step();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_err_sticky", 32'(MisalignErr), 32'h1);
`else
        chk("mis_err_sticky", 32'(MisalignErr), 32'h0);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("final_reset");
        #2;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
